// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: shared command/response codes and state types for the UART bus bridge
package uart_bridge_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ = 8'h52;
  localparam logic [7:0] RESP_ACK = 8'h06;
  localparam logic [7:0] RESP_NAK = 8'h15;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP, WAIT_TX} state_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;
endpackage

// File: rtl/bridge_timeout_counter.sv
// bridge_timeout_counter: counts ticks since the last clear, flags the Limit-th tick
module bridge_timeout_counter #(
  parameter int Limit = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expire
);
  localparam int W = $clog2(Limit + 1);
  logic [W-1:0] count;
  assign expire = tick && !clear && count == W'(Limit - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (tick && !expire) count <= count + 1'b1;
endmodule

// File: rtl/uart_bus_initiator.sv
// uart_bus_initiator: UART command frames in, one 32-bit bus read/write per frame, response bytes out
module uart_bus_initiator
  import uart_bridge_pkg::*;
#(
  parameter int FrameTimeout = 1000000,
  parameter int BusTimeout = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rxData,
  input  logic        rxDone,
  input  logic        rxErr,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txDone,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  strobe,
  output logic        ren,
  output logic        wen,
  input  logic [31:0] rdata,
  input  logic        request_stall,
  input  logic        error,
  output logic        busy
);
  state_t state, nextState;
  op_t op;
  logic [1:0] byteCnt, respCnt;
  logic [31:0] respBuf;
  logic frameExpire, busExpire, rxByte, cmdOk, inFrame, busDone, busAbort, readOk;
  assign rxByte = rxDone && !rxErr;
  assign cmdOk = rxData == CMD_WRITE || rxData == CMD_READ;
  assign inFrame = state == ADDR || state == DATA;
  assign busDone = state == BUS && !request_stall;
  assign busAbort = state == BUS && busExpire;
  assign readOk = busDone && !error && op == OP_READ;
  bridge_timeout_counter #(.Limit(FrameTimeout)) frameTimer (
    .clk(clk), .reset(reset), .clear(rxDone || !inFrame), .tick(1'b1), .expire(frameExpire)
  );
  bridge_timeout_counter #(.Limit(BusTimeout)) busTimer (
    .clk(clk), .reset(reset), .clear(state != BUS), .tick(request_stall), .expire(busExpire)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nextState;
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    nextState = rxErr ? IDLE : rxDone ? (cmdOk ? ADDR : RESP) : IDLE;
      ADDR:    nextState = (rxErr || frameExpire) ? IDLE :
                           (rxDone && byteCnt == 2'd3) ? (op == OP_WRITE ? DATA : BUS) : ADDR;
      DATA:    nextState = (rxErr || frameExpire) ? IDLE : (rxDone && byteCnt == 2'd3) ? BUS : DATA;
      BUS:     nextState = (busDone || busAbort) ? RESP : BUS;
      RESP:    nextState = WAIT_TX;
      WAIT_TX: nextState = txDone ? (respCnt != 2'd0 ? RESP : IDLE) : WAIT_TX;
      default: nextState = IDLE;
    endcase
  end
  always_comb begin
    busy = state != IDLE;
    txValid = state == RESP;
    txData = respBuf[31:24];
    strobe = wen ? 4'hF : 4'h0;
  end
  // Request is raised on the edge that accepts the last frame byte and held for the whole BUS stay
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op <= OP_READ;
      byteCnt <= '0;
      respCnt <= '0;
      respBuf <= '0;
      addr <= '0;
      wdata <= '0;
      ren <= 1'b0;
      wen <= 1'b0;
    end else begin
      if (state == IDLE && rxByte) begin
        op <= rxData == CMD_WRITE ? OP_WRITE : OP_READ;
        byteCnt <= '0;
        if (!cmdOk) begin
          respBuf <= {RESP_NAK, 24'h0};
          respCnt <= '0;
        end
      end
      if (state == ADDR && rxByte) begin
        addr <= {addr[23:0], rxData};
        byteCnt <= byteCnt + 2'd1;
        if (byteCnt == 2'd3 && op == OP_READ) ren <= 1'b1;
      end
      if (state == DATA && rxByte) begin
        wdata <= {wdata[23:0], rxData};
        byteCnt <= byteCnt + 2'd1;
        if (byteCnt == 2'd3) wen <= 1'b1;
      end
      if (busDone || busAbort) begin
        ren <= 1'b0;
        wen <= 1'b0;
        respBuf <= readOk ? rdata : {(busDone && !error) ? RESP_ACK : RESP_NAK, 24'h0};
        respCnt <= readOk ? 2'd3 : 2'd0;
      end
      if (state == WAIT_TX && txDone) begin
        respBuf <= {respBuf[23:0], 8'h0};
        respCnt <= respCnt - 2'(respCnt != 2'd0);
      end
    end
endmodule
